// File: rtl/sense_amp_array.sv
// sense_amp_array: multi-channel clocked comparator array with a metastability
// model, feeding the SAR logic of time-interleaved ADC slices.
//
// Each channel samples diff = vip - vin + OFFSET on a rising strobe. It then
// resolves after LAT cycles, or LAT + META_CYC cycles when |diff| < META_VTH.
// Decisions that resolved metastably raise meta. They are also tallied by a
// shared saturating counter.
//
// Optional feature macro: SENAMP_NOISE_EN. When it is defined, a 16-bit
// Fibonacci LFSR adds signed(lfsr[7:0]) * NOISE_LSB to each sampled diff.
// Channel i uses the LFSR rotated left by i bits.
//
// Request protocol: strobe is a level request, not a valid/ready pair. A 0->1
// transition seen on consecutive clk edges starts an evaluation. Keeping
// strobe high keeps the request alive until the decision latches and while it
// is held. Dropping strobe aborts a pending evaluation or releases a latched
// decision back to precharge.
//
// Ports:
//   clk       : single clock, all state updates on posedge
//   rst_n     : asynchronous active-low reset
//   strobe    : [NCH] per-channel compare request, sampled on clk
//   vip, vin  : real[NCH] differential inputs per channel
//   vmp, vmn  : [NCH] latch nodes, precharged high
//   vop, von  : [NCH] decision and its complement, held through precharge
//   done      : [NCH] decision valid (vmp ^ vmn)
//   meta      : [NCH] current decision resolved metastably
//   meta_cnt  : [CNT_W] saturating count of metastable decisions
//   fsm_state : [2*NCH] per-channel FSM state for observation (0 PRE, 1 EVAL, 2 LATCH)
module sense_amp_array #(
  parameter int  NCH       = 4,
  parameter int  LAT       = 2,
  parameter real META_VTH  = 1.0e-3,
  parameter int  META_CYC  = 4,
  parameter real OFFSET    = 0.0,
  parameter int  CNT_W     = 8,
  parameter real NOISE_LSB = 1.0e-5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   strobe,
  input  real              vip [NCH],
  input  real              vin [NCH],
  output logic [NCH-1:0]   vmp,
  output logic [NCH-1:0]   vmn,
  output logic [NCH-1:0]   vop,
  output logic [NCH-1:0]   von,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   meta,
  output logic [CNT_W-1:0] meta_cnt,
  output logic [2*NCH-1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_PRE   = 2'd0,
    ST_EVAL  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  // The counter holds L-1 for the longest latency L = LAT + META_CYC.
  localparam int CW = (LAT + META_CYC > 1) ? $clog2(LAT + META_CYC) : 1;
  localparam logic [CW-1:0] LOAD_N = CW'(LAT - 1);
  localparam logic [CW-1:0] LOAD_M = CW'(LAT + META_CYC - 1);
  localparam int IW = $clog2(NCH + 1);
  localparam int SW = CNT_W + IW;

  state_t            state_q [NCH];
  logic [CW-1:0]     cnt_q   [NCH];
  logic [NCH-1:0]    strb_q;
  logic [NCH-1:0]    d_q;
  logic [NCH-1:0]    m_q;

  real               noise_c [NCH];
  real               diff_c  [NCH];
  logic [NCH-1:0]    d_c;
  logic [NCH-1:0]    m_c;
  logic [NCH-1:0]    enter_c;
  logic [IW-1:0]     inc_c;
  logic [SW-1:0]     sum_c;
  logic [CNT_W-1:0]  sat_c;

`ifdef SENAMP_NOISE_EN
  logic [15:0] lfsr_q;

  // Taps 16,14,13,11 in right-shifting Fibonacci form. The register advances
  // every clock, whether or not any channel samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  function automatic real noise_of(input logic [15:0] l, input int sh);
    logic [15:0] rot;
    rot = (sh == 0) ? l : ((l << sh) | (l >> (16 - sh)));
    return real'($signed(rot[7:0])) * NOISE_LSB;
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      noise_c[i] = noise_of(lfsr_q, i % 16);
    end
  end
`else
  // Noise is absent. The product is still zero, but writing it this way keeps
  // NOISE_LSB referenced so both builds share one parameter list.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      noise_c[i] = 0.0 * NOISE_LSB;
    end
  end
`endif

  // Sampled-decision candidates. These are only captured on a rising strobe.
  // A tie (diff == 0) gives d=1, and it is always metastable.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      diff_c[i] = vip[i] - vin[i] + OFFSET + noise_c[i];
      d_c[i]    = (diff_c[i] >= 0.0);
      m_c[i]    = (diff_c[i] < META_VTH) && (diff_c[i] > -META_VTH);
    end
  end

  // Count the channels entering LATCH this edge with a metastable decision.
  always_comb begin
    inc_c   = '0;
    enter_c = '0;
    for (int i = 0; i < NCH; i++) begin
      enter_c[i] = (state_q[i] == ST_EVAL) && strobe[i] && (cnt_q[i] == '0);
      if (enter_c[i] && m_q[i]) begin
        inc_c = inc_c + IW'(1);
      end
    end
    sum_c = {{IW{1'b0}}, meta_cnt} + {{CNT_W{1'b0}}, inc_c};
    sat_c = (sum_c > {{IW{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];
  end

  always_comb begin
    fsm_state = '0;
    for (int i = 0; i < NCH; i++) begin
      fsm_state[2*i +: 2] = state_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vmp      <= '1;
      vmn      <= '1;
      vop      <= '0;
      von      <= '0;
      done     <= '0;
      meta     <= '0;
      meta_cnt <= '0;
      strb_q   <= '0;
      d_q      <= '0;
      m_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_PRE;
        cnt_q[i]   <= '0;
      end
    end else begin
      strb_q   <= strobe;
      meta_cnt <= sat_c;
      for (int i = 0; i < NCH; i++) begin
        case (state_q[i])
          ST_PRE: begin
            vmp[i]  <= 1'b1;
            vmn[i]  <= 1'b1;
            done[i] <= 1'b0;
            meta[i] <= 1'b0;
            if (strobe[i] && !strb_q[i]) begin
              d_q[i]     <= d_c[i];
              m_q[i]     <= m_c[i];
              cnt_q[i]   <= m_c[i] ? LOAD_M : LOAD_N;
              state_q[i] <= ST_EVAL;
            end
          end
          ST_EVAL: begin
            if (!strobe[i]) begin
              // Abort: the pending decision is discarded and no output moves.
              state_q[i] <= ST_PRE;
            end else if (cnt_q[i] == '0) begin
              state_q[i] <= ST_LATCH;
              vmp[i]     <= d_q[i];
              vop[i]     <= d_q[i];
              vmn[i]     <= ~d_q[i];
              von[i]     <= ~d_q[i];
              done[i]    <= 1'b1;
              meta[i]    <= m_q[i];
            end else begin
              cnt_q[i] <= cnt_q[i] - CW'(1);
            end
          end
          ST_LATCH: begin
            // vop/von are left alone, so the last decision survives precharge.
            if (!strobe[i]) begin
              state_q[i] <= ST_PRE;
              vmp[i]     <= 1'b1;
              vmn[i]     <= 1'b1;
              done[i]    <= 1'b0;
              meta[i]    <= 1'b0;
            end
          end
          default: begin
            state_q[i] <= ST_PRE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sense_amp_array.sv
// Directed testbench for sense_amp_array. Instance a uses the default
// parameters. Instance b uses CNT_W=2 and OFFSET=-0.01 to exercise counter
// saturation and input-referred offset. Inputs change 1 time unit after a
// rising clk edge, and outputs are checked at that same point.
module tb_sense_amp_array;

  logic       clk;
  logic       rst_n;

  logic [3:0] strobe_a;
  real        vip_a [4];
  real        vin_a [4];
  logic [3:0] vmp_a, vmn_a, vop_a, von_a, done_a, meta_a;
  logic [7:0] meta_cnt_a;
  logic [7:0] fsm_state_a;

  logic [3:0] strobe_b;
  real        vip_b [4];
  real        vin_b [4];
  logic [3:0] vmp_b, vmn_b, vop_b, von_b, done_b, meta_b;
  logic [1:0] meta_cnt_b;
  logic [7:0] fsm_state_b;

  int n_assert;
  int n_fail;

  sense_amp_array dut_a (
    .clk(clk), .rst_n(rst_n), .strobe(strobe_a), .vip(vip_a), .vin(vin_a),
    .vmp(vmp_a), .vmn(vmn_a), .vop(vop_a), .von(von_a), .done(done_a),
    .meta(meta_a), .meta_cnt(meta_cnt_a), .fsm_state(fsm_state_a)
  );

  sense_amp_array #(.CNT_W(2), .OFFSET(-0.01)) dut_b (
    .clk(clk), .rst_n(rst_n), .strobe(strobe_b), .vip(vip_b), .vin(vin_b),
    .vmp(vmp_b), .vmn(vmn_b), .vop(vop_b), .von(von_b), .done(done_b),
    .meta(meta_b), .meta_cnt(meta_cnt_b), .fsm_state(fsm_state_b)
  );

  // Clock / reset generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver helpers.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    strobe_a = '0;
    strobe_b = '0;
    for (int i = 0; i < 4; i++) begin
      vip_a[i] = 0.0; vin_a[i] = 0.0;
      vip_b[i] = 0.0; vin_b[i] = 0.0;
    end
    cycles(3);
    chk("rst_vmp", 32'(vmp_a), 32'hF);
    chk("rst_vmn", 32'(vmn_a), 32'hF);
    chk("rst_vop", 32'(vop_a), 32'h0);
    chk("rst_von", 32'(von_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_meta", 32'(meta_a), 32'h0);
    chk("rst_cnt", 32'(meta_cnt_a), 32'h0);
    chk("rst_state", 32'(fsm_state_a), 32'h0);
    rst_n = 1'b1;
    cycles(1);

    // Normal compare on ch0: the decision appears after edge k+2.
    vip_a[0] = 0.60; vin_a[0] = 0.40; strobe_a = 4'b0001;
    cycles(1);  // edge k
    chk("norm_state_eval", 32'(fsm_state_a), 32'h01);
    chk("norm_done_k", 32'(done_a), 32'h0);
    cycles(1);  // k+1
    chk("norm_done_k1", 32'(done_a), 32'h0);
    cycles(1);  // k+2
    chk("norm_vop", 32'(vop_a), 32'h1);
    chk("norm_von", 32'(von_a), 32'h0);
    chk("norm_vmp", 32'(vmp_a), 32'hF);
    chk("norm_vmn", 32'(vmn_a), 32'hE);
    chk("norm_done", 32'(done_a), 32'h1);
    chk("norm_meta", 32'(meta_a), 32'h0);
    chk("norm_state_latch", 32'(fsm_state_a), 32'h02);
    cycles(1);  // k+3, held
    chk("norm_hold_done", 32'(done_a), 32'h1);
    strobe_a = 4'b0000;
    cycles(1);  // k+4, precharge
    chk("pre_vmp", 32'(vmp_a), 32'hF);
    chk("pre_vmn", 32'(vmn_a), 32'hF);
    chk("pre_done", 32'(done_a), 32'h0);
    chk("pre_vop_hold", 32'(vop_a), 32'h1);
    chk("pre_von_hold", 32'(von_a), 32'h0);

    // Metastable on ch1: diff = -0.5 mV, so L = 2 + 4 = 6.
    vip_a[1] = 0.5000; vin_a[1] = 0.5005; strobe_a = 4'b0010;
    cycles(6);  // k+5
    chk("meta_not_early", 32'(done_a), 32'h0);
    cycles(1);  // k+6
    chk("meta_done", 32'(done_a), 32'h2);
    chk("meta_vop", 32'(vop_a), 32'h1);
    chk("meta_von", 32'(von_a), 32'h2);
    chk("meta_flag", 32'(meta_a), 32'h2);
    chk("meta_cnt1", 32'(meta_cnt_a), 32'h1);
    strobe_a = 4'b0000;
    cycles(1);
    chk("meta_clear", 32'(meta_a), 32'h0);
    chk("meta_cnt_keep", 32'(meta_cnt_a), 32'h1);

    // Tie on ch2: d = 1 and the decision is metastable.
    vip_a[2] = 0.3; vin_a[2] = 0.3; strobe_a = 4'b0100;
    cycles(7);
    chk("tie_vop", 32'(vop_a), 32'h5);
    chk("tie_meta", 32'(meta_a), 32'h4);
    chk("tie_cnt", 32'(meta_cnt_a), 32'h2);
    strobe_a = 4'b0000;
    cycles(1);

    // Abort on ch0: a one-cycle strobe gives no decision.
    vip_a[0] = 0.40; vin_a[0] = 0.60; strobe_a = 4'b0001;
    cycles(1);
    strobe_a = 4'b0000;
    cycles(4);
    chk("abort_done", 32'(done_a), 32'h0);
    chk("abort_vop", 32'(vop_a), 32'h5);
    chk("abort_von", 32'(von_a), 32'h2);
    chk("abort_cnt", 32'(meta_cnt_a), 32'h2);
    // The next rise evaluates normally.
    strobe_a = 4'b0001;
    cycles(3);
    chk("reeval_done", 32'(done_a), 32'h1);
    chk("reeval_vop", 32'(vop_a), 32'h4);
    chk("reeval_von", 32'(von_a), 32'h3);
    // Holding strobe high after LATCH does not re-evaluate new inputs.
    vip_a[0] = 0.90;
    cycles(4);
    chk("hold_no_reeval", 32'(vop_a), 32'h4);
    chk("hold_done", 32'(done_a), 32'h1);
    strobe_a = 4'b0000;
    cycles(1);

    // Offset on instance b: a +5 mV input with a -10 mV offset decides 0.
    vip_b[0] = 0.505; vin_b[0] = 0.500;
    vip_b[1] = 0.530; vin_b[1] = 0.500;
    strobe_b = 4'b0011;
    cycles(3);
    chk("ofs_done", 32'(done_b), 32'h3);
    chk("ofs_vop", 32'(vop_b), 32'h2);
    chk("ofs_meta", 32'(meta_b), 32'h0);
    strobe_b = 4'b0000;
    cycles(1);

    // Saturation on instance b (CNT_W=2). diff is about 0 after the offset.
    for (int i = 0; i < 4; i++) begin
      vip_b[i] = 0.51; vin_b[i] = 0.50;
    end
    strobe_b = 4'b0011;
    cycles(7);
    chk("sat_two_same_edge", 32'(meta_cnt_b), 32'h2);
    strobe_b = 4'b0000;
    cycles(1);
    strobe_b = 4'b1111;
    cycles(6);
    chk("sat_not_early", 32'(meta_cnt_b), 32'h2);
    cycles(1);
    chk("sat_all_meta", 32'(meta_b), 32'hF);
    chk("sat_cnt3", 32'(meta_cnt_b), 32'h3);
    strobe_b = 4'b0000;
    cycles(1);
    strobe_b = 4'b1111;
    cycles(7);
    chk("sat_hold3", 32'(meta_cnt_b), 32'h3);
    chk("sat_done", 32'(done_b), 32'hF);
    strobe_b = 4'b0000;
    cycles(1);

    // Reset mid-EVAL on ch0 clears everything without waiting for a clock.
    vip_a[0] = 0.60; vin_a[0] = 0.40; strobe_a = 4'b0001;
    cycles(1);
    chk("mid_state_eval", 32'(fsm_state_a), 32'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vmp", 32'(vmp_a), 32'hF);
    chk("arst_vmn", 32'(vmn_a), 32'hF);
    chk("arst_vop", 32'(vop_a), 32'h0);
    chk("arst_von", 32'(von_a), 32'h0);
    chk("arst_done", 32'(done_a), 32'h0);
    chk("arst_meta", 32'(meta_a), 32'h0);
    chk("arst_cnt", 32'(meta_cnt_a), 32'h0);
    chk("arst_cnt_b", 32'(meta_cnt_b), 32'h0);
    strobe_a = 4'b0000;
    cycles(2);
    rst_n = 1'b1;
    cycles(5);
    chk("post_rst_done", 32'(done_a), 32'h0);
    chk("post_rst_vop", 32'(vop_a), 32'h0);
    chk("post_rst_state", 32'(fsm_state_a), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sense_amp_array.md
Name: sense_amp_array

Overview:
Multi-channel, clocked successor to the single ideal SAR comparator model. Each channel has a sampled strobe, a fixed resolution latency and a metastability model: small differential inputs resolve later and raise a flag. A shared saturating counter tallies metastable decisions. The block sits between the CDAC real-valued outputs and the SAR logic of time-interleaved ADC slices.

Parameters:
NCH, 4, number of comparator channels (>=1)
LAT, 2, cycles from strobe rise sample to decision (>=1)
META_VTH, 1.0e-3, real, V; |diff| below this is metastable
META_CYC, 4, extra resolution cycles for metastable decisions (>=0)
OFFSET, 0.0, real, V; input-referred offset added to every channel
CNT_W, 8, width of metastability event counter
NOISE_LSB, 1.0e-5, real, V per LFSR step (used only with SENAMP_NOISE_EN)

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
strobe  input  NCH  per-channel compare request, level-sensitive, sampled on clk
vip  input  real[NCH]  positive input per channel
vin  input  real[NCH]  negative input per channel
vmp  output  NCH  internal latch node P; precharged high
vmn  output  NCH  internal latch node N; precharged high
vop  output  NCH  decision, 1 = vip side higher; holds through precharge
von  output  NCH  complement decision; holds through precharge
done  output  NCH  decision valid; equals vmp^vmn
meta  output  NCH  current decision was metastable
meta_cnt  output  CNT_W  saturating count of metastable decisions, all channels

Behaviour:
- Reset (async assert, sync release): vmp=vmn=all 1, vop=von=0, done=0, meta=0, meta_cnt=0, every channel in PRE, strobe history=0, eval counters=0. Reset mid-evaluation discards the pending decision immediately.
- Per-channel FSM: PRE, EVAL, LATCH.
- PRE: vmp=vmn=1, done=0, meta=0.
  - Rising strobe (strobe=1, previous sampled strobe=0) at edge k samples diff = vip-vin+OFFSET.
  - Sets m = (|diff| < META_VTH) and d = (diff >= 0.0); a tie gives d=1, m=1.
  - Loads counter with L-1, where L = LAT + (m ? META_CYC : 0). Goes to EVAL.
  - Strobe held high from reset counts as a rise, because history resets to 0.
- EVAL:
  - strobe=0 aborts to PRE. No outputs change and meta_cnt is unchanged.
  - Otherwise the counter decrements. At the edge where it is 0, go to LATCH.
  - Decision visible after edge k+L: vmp=vop=d, vmn=von=~d, done=1, meta=m.
- LATCH: outputs held while strobe=1. strobe=0 at an edge goes to PRE: vmp=vmn=1, done=0, meta=0; vop/von keep the last decision.
- A new rise needs strobe low for at least one sampled edge. Strobe held high after LATCH gives no re-evaluation.
- meta_cnt: at each edge, add the number of channels entering LATCH with m=1. Saturate at 2^CNT_W-1; never wraps.
- Channels are independent; any mix of states in the same cycle is legal.
- Inputs are sampled only on a rise edge. vip/vin changes during EVAL are ignored.

Optional Feature:
Macro SENAMP_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) resets to 16'hACE1 and advances every clk.
  - At each rise sample, diff gains signed(lfsr[7:0])*NOISE_LSB. Channel i uses lfsr rotated left by i bits.
  - The m and d evaluations use the noisy diff.
- Undefined: no LFSR logic; noise term is 0.0; behaviour fully deterministic as above.

Test Plan:
1. Reset: rst_n=0 mid-EVAL on ch0 -> immediately vmp=vmn=4'hF, vop=von=0, done=0, meta=0, meta_cnt=0; after release no decision appears.
2. Normal compare, LAT=2, ch0 vip=0.60 vin=0.40, strobe rises at edge k -> after k+2 vop=1 von=0 vmp=1 vmn=0 done=1 meta=0; strobe low at k+4 -> vmp=vmn=1, done=0, vop stays 1.
3. Metastable, META_CYC=4, vip=0.5000 vin=0.5005 -> decision at k+6: vop=0 von=1 meta=1, meta_cnt=1; tie vip=vin -> vop=1, meta=1.
4. Abort: strobe high at k, low at k+1 -> done never asserts, vop/von unchanged, meta_cnt unchanged; next rise evaluates normally.
5. Saturation, CNT_W=2, meta_cnt=2: all 4 channels metastable and latching same edge -> meta_cnt=3; further events keep 3.
6. Offset, OFFSET=-0.01, vip-vin=+0.005 -> vop=0, meta=0; with SENAMP_NOISE_EN the first-decision sequence from seed 16'hACE1 must match the golden model.
